// File: rtl/choreo_pkg.sv
// choreo_pkg: shared pattern width, pattern codes and the pattern-sequence step.
package choreo_pkg;
    localparam int PAT_W = 3;
    typedef enum logic [PAT_W-1:0] {
        PAT_KNIGHT  = 3'd0,
        PAT_WALK    = 3'd1,
        PAT_EXPAND  = 3'd2,
        PAT_BLINK   = 3'd3,
        PAT_ALT     = 3'd4,
        PAT_MARQUEE = 3'd5,
        PAT_SPARKLE = 3'd6,
        PAT_OFF     = 3'd7
    } pat_e;
    // With skip set, both SPARKLE and a stray OFF wrap back to KNIGHT.
    function automatic logic [PAT_W-1:0] next_pat(input logic [PAT_W-1:0] p, input logic skip);
        return (skip && p >= PAT_SPARKLE) ? PAT_KNIGHT : p + PAT_W'(1);
    endfunction
endpackage

// File: rtl/choreo_input_ctrl_if.sv
// choreo_input_ctrl_if: front-panel bundle; raw buttons/auto_en in, pat_sel/speed_sel/pause/pat_changed out.
interface choreo_input_ctrl_if;
    import choreo_pkg::*;
    logic             btn_next_raw;
    logic             btn_pause_raw;
    logic             btn_speed_raw;
    logic             auto_en;
    logic [PAT_W-1:0] pat_sel;
    logic             speed_sel;
    logic             pause;
    logic             pat_changed;
    modport master (
        output btn_next_raw, btn_pause_raw, btn_speed_raw, auto_en,
        input  pat_sel, speed_sel, pause, pat_changed
    );
    modport slave (
        input  btn_next_raw, btn_pause_raw, btn_speed_raw, auto_en,
        output pat_sel, speed_sel, pause, pat_changed
    );
endinterface

// File: rtl/choreo_btn_debounce.sv
// choreo_btn_debounce: 2-FF sync + debounce of one raw button; clk, rst, raw in; one-cycle press out.
module choreo_btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press
);
    localparam logic [7:0] DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
    logic [1:0] sync_q, sync_d;
    logic [7:0] cnt_q, cnt_d;
    logic       stable_q, stable_d, stable_dly_q, stable_dly_d;
    logic       differ, last;
    always_comb begin
        sync_d       = {sync_q[0], raw};
        differ       = sync_q[1] != stable_q;
        last         = cnt_q == DEB_LAST;
        cnt_d        = (!differ || last) ? '0 : cnt_q + 8'd1;
        stable_d     = (differ && last) ? sync_q[1] : stable_q;
        stable_dly_d = stable_q;
        press        = stable_q & ~stable_dly_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q       <= '0;
            cnt_q        <= '0;
            stable_q     <= 1'b0;
            stable_dly_q <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            cnt_q        <= cnt_d;
            stable_q     <= stable_d;
            stable_dly_q <= stable_dly_d;
        end
    end
endmodule

// File: rtl/choreo_input_ctrl.sv
// choreo_input_ctrl: debounced panel buttons + auto-cycle timer; clk, rst, bus (slave) carrying buttons, auto_en and generator controls.
module choreo_input_ctrl import choreo_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_CYCLES     = 32,
    parameter int SKIP_OFF        = 1
) (
    input logic                clk,
    input logic                rst,
    choreo_input_ctrl_if.slave bus
);
    localparam logic [15:0] AUTO_LAST = 16'(AUTO_CYCLES - 1);
    logic             next_press, pause_press, speed_press;
    logic [1:0]       auto_sync_q, auto_sync_d;
    logic [15:0]      auto_cnt_q, auto_cnt_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             speed_q, speed_d, pause_q, pause_d, chg_q, chg_d;
    logic             auto_on, expire, adv;
    choreo_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk(clk), .rst(rst), .raw(bus.btn_next_raw), .press(next_press)
    );
    choreo_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pause (
        .clk(clk), .rst(rst), .raw(bus.btn_pause_raw), .press(pause_press)
    );
    choreo_btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_speed (
        .clk(clk), .rst(rst), .raw(bus.btn_speed_raw), .press(speed_press)
    );
    always_comb begin
        auto_sync_d = {auto_sync_q[0], bus.auto_en};
        auto_on     = auto_sync_q[1];
        expire      = auto_on && !pause_q && auto_cnt_q == AUTO_LAST;
        adv         = next_press | expire;
        // A manual press restarts the interval; pause freezes it mid-count.
        auto_cnt_d  = (!auto_on || next_press || expire) ? '0 :
                      pause_q ? auto_cnt_q : auto_cnt_q + 16'd1;
        pat_d       = adv ? next_pat(pat_q, SKIP_OFF != 0) : pat_q;
        chg_d       = adv;
        pause_d     = pause_q ^ pause_press;
        speed_d     = speed_q ^ speed_press;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_sync_q <= '0;
            auto_cnt_q  <= '0;
            pat_q       <= PAT_KNIGHT;
            speed_q     <= 1'b0;
            pause_q     <= 1'b0;
            chg_q       <= 1'b0;
        end else begin
            auto_sync_q <= auto_sync_d;
            auto_cnt_q  <= auto_cnt_d;
            pat_q       <= pat_d;
            speed_q     <= speed_d;
            pause_q     <= pause_d;
            chg_q       <= chg_d;
        end
    end
    assign bus.pat_sel     = pat_q;
    assign bus.speed_sel   = speed_q;
    assign bus.pause       = pause_q;
    assign bus.pat_changed = chg_q;
endmodule

// File: tb/tb_choreo_input_ctrl.sv
// tb_choreo_input_ctrl: directed checks of debounce latency, bounce rejection, wrap, auto-cycle, pause and reset.
module tb_choreo_input_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   passed = 0;
    logic [2:0] exp_a [7] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd0};
    logic [2:0] exp_b [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};

    always #5 clk = ~clk;

    choreo_input_ctrl_if ifa ();
    choreo_input_ctrl_if ifb ();

    choreo_input_ctrl #(.DEBOUNCE_CYCLES(4), .AUTO_CYCLES(16), .SKIP_OFF(1)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa.slave)
    );
    choreo_input_ctrl #(.DEBOUNCE_CYCLES(4), .AUTO_CYCLES(16), .SKIP_OFF(0)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb.slave)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
    endtask

    initial begin
        ifa.btn_next_raw = 0; ifa.btn_pause_raw = 0; ifa.btn_speed_raw = 0; ifa.auto_en = 0;
        ifb.btn_next_raw = 0; ifb.btn_pause_raw = 0; ifb.btn_speed_raw = 0; ifb.auto_en = 0;
        step(2);
        check("rst_pat", ifa.pat_sel, 0);
        check("rst_speed", ifa.speed_sel, 0);
        check("rst_pause", ifa.pause, 0);
        check("rst_chg", ifa.pat_changed, 0);

        // 1: held next button steps exactly once at edge 7
        rst = 1'b0;
        ifa.btn_next_raw = 1;
        step(6);
        check("lat_e6_pat", ifa.pat_sel, 0);
        check("lat_e6_chg", ifa.pat_changed, 0);
        step(1);
        check("lat_e7_pat", ifa.pat_sel, 1);
        check("lat_e7_chg", ifa.pat_changed, 1);
        step(1);
        check("lat_e8_chg", ifa.pat_changed, 0);
        step(12);
        check("held_once", ifa.pat_sel, 1);
        ifa.btn_next_raw = 0;
        step(10);
        check("release_none", ifa.pat_sel, 1);

        // 2: 1-high/1-low bounce never debounces
        for (int i = 0; i < 20; i++) begin
            ifa.btn_next_raw = (i % 2 == 0);
            step(1);
        end
        ifa.btn_next_raw = 0;
        step(10);
        check("bounce_pat", ifa.pat_sel, 1);

        // 3: wrap sequences with and without OFF skipping
        do_reset();
        for (int i = 0; i < 7; i++) begin
            ifa.btn_next_raw = 1;
            step(8);
            ifa.btn_next_raw = 0;
            step(8);
            check($sformatf("skip1_seq%0d", i), ifa.pat_sel, exp_a[i]);
        end
        for (int i = 0; i < 8; i++) begin
            ifb.btn_next_raw = 1;
            step(8);
            ifb.btn_next_raw = 0;
            step(8);
            check($sformatf("skip0_seq%0d", i), ifb.pat_sel, exp_b[i]);
        end

        // 4: auto-cycle every 16, pause freezes the count, auto_en off halts
        do_reset();
        ifa.auto_en = 1;
        step(17);
        check("auto_e17", ifa.pat_sel, 0);
        step(1);
        check("auto_e18", ifa.pat_sel, 1);
        check("auto_e18_chg", ifa.pat_changed, 1);
        step(15);
        check("auto_e33", ifa.pat_sel, 1);
        step(1);
        check("auto_e34", ifa.pat_sel, 2);
        step(5);
        ifa.btn_pause_raw = 1;
        step(8);
        check("pause_on", ifa.pause, 1);
        ifa.btn_pause_raw = 0;
        step(20);
        check("paused_hold", ifa.pat_sel, 2);
        ifa.btn_pause_raw = 1;
        step(8);
        check("pause_off", ifa.pause, 0);
        ifa.btn_pause_raw = 0;
        step(2);
        check("resume_e77", ifa.pat_sel, 2);
        step(1);
        check("resume_e78", ifa.pat_sel, 3);
        ifa.auto_en = 0;
        step(40);
        check("auto_off", ifa.pat_sel, 3);

        // 5: manual press coinciding with expiry gives one step
        do_reset();
        ifa.auto_en = 1;
        step(11);
        ifa.btn_next_raw = 1;
        step(7);
        check("coincide_single", ifa.pat_sel, 1);
        ifa.btn_next_raw = 0;
        step(15);
        check("restart_e33", ifa.pat_sel, 1);
        step(1);
        check("restart_e34", ifa.pat_sel, 2);

        // 6: reset mid-debounce with speed_sel set; held button re-presses after release
        ifa.auto_en = 0;
        ifa.btn_speed_raw = 1;
        step(8);
        ifa.btn_speed_raw = 0;
        step(8);
        check("speed_set", ifa.speed_sel, 1);
        ifa.btn_next_raw = 1;
        step(4);
        rst = 1'b1;
        step(1);
        check("mid_rst_pat", ifa.pat_sel, 0);
        check("mid_rst_speed", ifa.speed_sel, 0);
        check("mid_rst_pause", ifa.pause, 0);
        check("mid_rst_chg", ifa.pat_changed, 0);
        step(2);
        rst = 1'b0;
        step(6);
        check("post_rst_e6", ifa.pat_sel, 0);
        step(1);
        check("post_rst_e7", ifa.pat_sel, 1);
        check("post_rst_chg", ifa.pat_changed, 1);
        ifa.btn_next_raw = 0;
        step(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
